l15_if_retime: RTL and testbench



---
 rtl/l15_if_retime_pkg.sv | 21 ++
 rtl/l15_if_retime_rtrn_fifo.sv | 80 ++++++++
 rtl/l15_if_retime.sv | 177 +++++++++++++++++
 tb/tb_l15_if_retime.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l15_if_retime_pkg.sv
// l15_if_retime_pkg
//   Shared types and constants for the L1.5 retiming stage.
//   - l15_req_state_e : request-path FSM states
//   - PerfCntWidth    : width of the optional performance counters
//   - sat_inc()       : saturating increment used by those counters
package l15_if_retime_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } l15_req_state_e;

  localparam int unsigned PerfCntWidth = 32;

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [PerfCntWidth-1:0] sat_inc(input logic [PerfCntWidth-1:0] v);
    return (&v) ? v : v + PerfCntWidth'(1);
  endfunction

endpackage

// File: rtl/l15_if_retime_rtrn_fifo.sv
// l15_rtrn_fifo
//   Generic register-based FIFO. The head entry is presented on data_o
//   straight from the storage registers, so the read side has no extra
//   latency. A push is accepted while full as long as a pop happens in the
//   same cycle; the entry being freed at the head is then reused.
//   Depth must be at least 2.
//
// Ports
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (empties the FIFO, clears storage)
//   push_i  : write data_i at the tail
//   data_i  : write data
//   pop_i   : drop the head entry (ignored when empty)
//   data_o  : head entry
//   full_o  : all Depth entries occupied
//   empty_o : no entry occupied
//   usage_o : number of occupied entries
module l15_rtrn_fifo #(
  parameter int unsigned Depth      = 2,
  parameter int unsigned DataWidth  = 384,
  localparam int unsigned PtrWidth  = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned UsageWidth = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DataWidth-1:0]  data_i,
  input  logic                  pop_i,
  output logic [DataWidth-1:0]  data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [UsageWidth-1:0] usage_o
);

  logic [DataWidth-1:0]  mem_reg [Depth];
  logic [PtrWidth-1:0]   wr_ptr_reg;
  logic [PtrWidth-1:0]   rd_ptr_reg;
  logic [UsageWidth-1:0] usage_reg;
  logic                  wr_en;
  logic                  rd_en;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign full_o  = (usage_reg == UsageWidth'(Depth));
  assign empty_o = (usage_reg == '0);
  assign usage_o = usage_reg;
  assign rd_en   = pop_i & ~empty_o;
  assign wr_en   = push_i & (~full_o | rd_en);
  assign data_o  = mem_reg[rd_ptr_reg];

  for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        mem_reg[gi] <= '0;
      end else if (wr_en && (wr_ptr_reg == PtrWidth'(gi))) begin
        mem_reg[gi] <= data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      usage_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (rd_en) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({wr_en, rd_en})
        2'b10:   usage_reg <= usage_reg + UsageWidth'(1);
        2'b01:   usage_reg <= usage_reg - UsageWidth'(1);
        default: usage_reg <= usage_reg;
      endcase
    end
  end

endmodule

// File: rtl/l15_if_retime.sv
// l15_if_retime
//   Elastic timing stage between the core-side L1.5 port and the L1.5 cache.
//   The request path is a three-state register stage (IDLE/PEND/ACK) obeying
//   the hold-until-header-ack protocol; the return path is a small FIFO with
//   registered ack toward L1.5 and a one-cycle valid gap after each pop
//   toward the core. Every output is driven from flops only.
//   Optional performance counters are enabled by defining
//   L15_IF_RETIME_PERF_EN.
//
// Ports
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   core_req_val_i         : core request valid (held until header ack)
//   core_req_payload_i     : core request fields
//   core_req_header_ack_o  : one-cycle header ack to the core
//   l15_req_val_o          : request valid to L1.5
//   l15_req_payload_o      : registered request fields
//   l15_header_ack_i       : header ack from L1.5
//   l15_rtrn_val_i         : return valid from L1.5 (held until ack)
//   l15_rtrn_payload_i     : return fields
//   l15_req_ack_o          : one-cycle return ack to L1.5
//   core_rtrn_val_o        : return valid to the core
//   core_rtrn_payload_o    : FIFO head
//   core_rtrn_ack_i        : core consumes the head
//   perf_req_cnt_o         : (PERF) requests acked by L1.5
//   perf_req_stall_o       : (PERF) cycles spent waiting in PEND
//   perf_rtrn_full_o       : (PERF) cycles with a return blocked by a full FIFO
module l15_if_retime
  import l15_if_retime_pkg::*;
#(
  parameter int unsigned ReqPayloadWidth  = 256,
  parameter int unsigned RtrnPayloadWidth = 384,
  parameter int unsigned RtrnFifoDepth    = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        core_req_val_i,
  input  logic [ReqPayloadWidth-1:0]  core_req_payload_i,
  output logic                        core_req_header_ack_o,
  output logic                        l15_req_val_o,
  output logic [ReqPayloadWidth-1:0]  l15_req_payload_o,
  input  logic                        l15_header_ack_i,
  input  logic                        l15_rtrn_val_i,
  input  logic [RtrnPayloadWidth-1:0] l15_rtrn_payload_i,
  output logic                        l15_req_ack_o,
  output logic                        core_rtrn_val_o,
  output logic [RtrnPayloadWidth-1:0] core_rtrn_payload_o,
  input  logic                        core_rtrn_ack_i
`ifdef L15_IF_RETIME_PERF_EN
  ,
  output logic [PerfCntWidth-1:0]     perf_req_cnt_o,
  output logic [PerfCntWidth-1:0]     perf_req_stall_o,
  output logic [PerfCntWidth-1:0]     perf_rtrn_full_o
`endif
);

  localparam int unsigned UsageWidth = $clog2(RtrnFifoDepth + 1);

  // ---------------------------------------------------------------- request
  l15_req_state_e             state_reg;
  logic                       l15_req_val_reg;
  logic                       hdr_ack_reg;
  logic [ReqPayloadWidth-1:0] req_payload_reg;

  // Outputs are registered alongside the state so nothing is decoded
  // combinationally on the way out of the tile.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= IDLE;
      l15_req_val_reg <= 1'b0;
      hdr_ack_reg     <= 1'b0;
      req_payload_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (core_req_val_i) begin
            req_payload_reg <= core_req_payload_i;
            l15_req_val_reg <= 1'b1;
            state_reg       <= PEND;
          end
        end
        PEND: begin
          if (l15_header_ack_i) begin
            l15_req_val_reg <= 1'b0;
            hdr_ack_reg     <= 1'b1;
            state_reg       <= ACK;
          end
        end
        ACK: begin
          // Core still holds its old request this cycle; do not recapture it.
          hdr_ack_reg <= 1'b0;
          state_reg   <= IDLE;
        end
        default: begin
          l15_req_val_reg <= 1'b0;
          hdr_ack_reg     <= 1'b0;
          state_reg       <= IDLE;
        end
      endcase
    end
  end

  assign l15_req_val_o         = l15_req_val_reg;
  assign l15_req_payload_o     = req_payload_reg;
  assign core_req_header_ack_o = hdr_ack_reg;

  // ----------------------------------------------------------------- return
  logic                  rtrn_push;
  logic                  rtrn_pop;
  logic                  rtrn_full;
  logic                  rtrn_empty;
  logic [UsageWidth-1:0] rtrn_usage;
  logic                  ack_reg;
  logic                  gap_reg;
  logic                  unused_usage;

  // A full FIFO still accepts a return when the head leaves in the same
  // cycle. ack_reg blocks the second sample of a return L1.5 is still
  // holding during its ack cycle.
  assign rtrn_push = l15_rtrn_val_i & (~rtrn_full | rtrn_pop) & ~ack_reg;

  // gap_reg hides the new head for one cycle after a pop so a core that
  // registers its ack cannot consume two entries with one ack.
  assign core_rtrn_val_o = ~rtrn_empty & ~gap_reg;
  assign rtrn_pop        = core_rtrn_val_o & core_rtrn_ack_i;
  assign l15_req_ack_o   = ack_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_reg <= 1'b0;
      gap_reg <= 1'b0;
    end else begin
      ack_reg <= rtrn_push;
      gap_reg <= rtrn_pop;
    end
  end

  l15_rtrn_fifo #(
    .Depth     (RtrnFifoDepth),
    .DataWidth (RtrnPayloadWidth)
  ) u_rtrn_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rtrn_push),
    .data_i  (l15_rtrn_payload_i),
    .pop_i   (rtrn_pop),
    .data_o  (core_rtrn_payload_o),
    .full_o  (rtrn_full),
    .empty_o (rtrn_empty),
    .usage_o (rtrn_usage)
  );

  assign unused_usage = ^rtrn_usage;

  // ------------------------------------------------------------ performance
`ifdef L15_IF_RETIME_PERF_EN
  logic [PerfCntWidth-1:0] perf_req_cnt_reg;
  logic [PerfCntWidth-1:0] perf_req_stall_reg;
  logic [PerfCntWidth-1:0] perf_rtrn_full_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_req_cnt_reg   <= '0;
      perf_req_stall_reg <= '0;
      perf_rtrn_full_reg <= '0;
    end else begin
      if ((state_reg == PEND) && l15_header_ack_i) perf_req_cnt_reg <= sat_inc(perf_req_cnt_reg);
      if (state_reg == PEND) perf_req_stall_reg <= sat_inc(perf_req_stall_reg);
      if (l15_rtrn_val_i && rtrn_full) perf_rtrn_full_reg <= sat_inc(perf_rtrn_full_reg);
    end
  end

  assign perf_req_cnt_o   = perf_req_cnt_reg;
  assign perf_req_stall_o = perf_req_stall_reg;
  assign perf_rtrn_full_o = perf_rtrn_full_reg;
`endif

endmodule

// File: tb/tb_l15_if_retime.sv
// tb_l15_if_retime
//   Directed walk through the request handshake, return buffering, the pop
//   gap and asynchronous reset, followed by a randomized run. A transaction
//   level model (a queue for the return FIFO, plain flags for the request
//   handshake) predicts every output each cycle.
module tb_l15_if_retime;

  localparam int REQ_W = 256;
  localparam int RTN_W = 384;
  localparam int DEPTH = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             core_req_val_i = 1'b0;
  logic [REQ_W-1:0] core_req_payload_i = '0;
  logic             core_req_header_ack_o;
  logic             l15_req_val_o;
  logic [REQ_W-1:0] l15_req_payload_o;
  logic             l15_header_ack_i = 1'b0;
  logic             l15_rtrn_val_i = 1'b0;
  logic [RTN_W-1:0] l15_rtrn_payload_i = '0;
  logic             l15_req_ack_o;
  logic             core_rtrn_val_o;
  logic [RTN_W-1:0] core_rtrn_payload_o;
  logic             core_rtrn_ack_i = 1'b0;

  l15_if_retime #(
    .ReqPayloadWidth  (REQ_W),
    .RtrnPayloadWidth (RTN_W),
    .RtrnFifoDepth    (DEPTH)
  ) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .core_req_val_i        (core_req_val_i),
    .core_req_payload_i    (core_req_payload_i),
    .core_req_header_ack_o (core_req_header_ack_o),
    .l15_req_val_o         (l15_req_val_o),
    .l15_req_payload_o     (l15_req_payload_o),
    .l15_header_ack_i      (l15_header_ack_i),
    .l15_rtrn_val_i        (l15_rtrn_val_i),
    .l15_rtrn_payload_i    (l15_rtrn_payload_i),
    .l15_req_ack_o         (l15_req_ack_o),
    .core_rtrn_val_o       (core_rtrn_val_o),
    .core_rtrn_payload_o   (core_rtrn_payload_o),
    .core_rtrn_ack_i       (core_rtrn_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model
  bit               m_req_out;     // a request is being offered to L1.5
  bit               m_hdr_ack;     // header ack being returned to the core
  logic [REQ_W-1:0] m_req_pl;
  logic [RTN_W-1:0] m_q[$];        // returns accepted but not yet consumed
  bit               m_ack;         // return accepted on the previous edge
  bit               m_gap;         // head was consumed on the previous edge

  task automatic model_reset();
    m_req_out = 0; m_hdr_ack = 0; m_req_pl = '0;
    m_q.delete(); m_ack = 0; m_gap = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    bit vis, pop, push;
    vis  = (m_q.size() != 0) && !m_gap;
    pop  = vis && core_rtrn_ack_i;
    push = l15_rtrn_val_i && ((m_q.size() < DEPTH) || pop) && !m_ack;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(l15_rtrn_payload_i);
    m_ack = push;
    m_gap = pop;
    if (m_hdr_ack) begin
      m_hdr_ack = 0;                       // core request ignored while acking
    end else if (m_req_out) begin
      if (l15_header_ack_i) begin
        m_req_out = 0;
        m_hdr_ack = 1;
      end
    end else if (core_req_val_i) begin
      m_req_out = 1;
      m_req_pl  = core_req_payload_i;
    end
  endtask

  task automatic chk(input string tag, input logic [RTN_W-1:0] obs, input logic [RTN_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit vis;
    vis = (m_q.size() != 0) && !m_gap;
    chk("l15_req_val", l15_req_val_o, m_req_out);
    if (m_req_out) chk("l15_req_payload", l15_req_payload_o, m_req_pl);
    chk("core_req_header_ack", core_req_header_ack_o, m_hdr_ack);
    chk("l15_req_ack", l15_req_ack_o, m_ack);
    chk("core_rtrn_val", core_rtrn_val_o, vis);
    if (vis) chk("core_rtrn_payload", core_rtrn_payload_o, m_q[0]);
  endtask

  // One clock: model crosses the edge, then outputs are compared at the
  // following falling edge, where the next inputs are also applied.
  task automatic tick();
    model_step();
    @(negedge clk_i);
    check_all();
  endtask

  function automatic logic [RTN_W-1:0] rand_vec();
    logic [RTN_W-1:0] v;
    for (int i = 0; i < RTN_W / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_l15_req_val"}, l15_req_val_o, 0);
    chk({tag, "_l15_req_payload"}, l15_req_payload_o, 0);
    chk({tag, "_core_req_header_ack"}, core_req_header_ack_o, 0);
    chk({tag, "_l15_req_ack"}, l15_req_ack_o, 0);
    chk({tag, "_core_rtrn_val"}, core_rtrn_val_o, 0);
    chk({tag, "_core_rtrn_payload"}, core_rtrn_payload_o, 0);
  endtask

  initial begin
    logic [RTN_W-1:0] r_vals [3];
    logic [RTN_W-1:0] popped [$];
    int  idx, acks, mode;
    bit  l15_seen_ack, core_seen_ack;

    model_reset();
    repeat (3) @(negedge clk_i);
    chk_all_zero("reset");
    rst_ni = 1'b1;
    check_all();

    // ---- single request, header ack at cycle 4
    core_req_val_i = 1'b1; core_req_payload_i = REQ_W'('hA5);       // cycle 0
    tick();                                                           // cycle 1
    chk("req_c1_val", l15_req_val_o, 1);
    chk("req_c1_payload", l15_req_payload_o, 'hA5);
    tick(); tick(); tick();                                           // cycle 4
    chk("req_c4_val", l15_req_val_o, 1);
    l15_header_ack_i = 1'b1;
    tick();                                                           // cycle 5
    l15_header_ack_i = 1'b0;
    chk("req_c5_hdr_ack", core_req_header_ack_o, 1);
    chk("req_c5_val", l15_req_val_o, 0);
    core_req_payload_i = REQ_W'('h5A);   // still valid during ACK: must be ignored
    tick();                                                           // cycle 6
    chk("req_c6_hdr_ack", core_req_header_ack_o, 0);
    chk("req_c6_val", l15_req_val_o, 0);
    tick();                                                           // cycle 7
    chk("req_c7_val", l15_req_val_o, 1);
    chk("req_c7_payload", l15_req_payload_o, 'h5A);
    l15_header_ack_i = 1'b1;
    tick();
    l15_header_ack_i = 1'b0; core_req_val_i = 1'b0;
    tick();
    tick();

    // ---- three returns into a depth-2 FIFO with the core stalled
    for (int i = 0; i < 3; i++) r_vals[i] = rand_vec();
    idx = 0; acks = 0; l15_seen_ack = 0;
    l15_rtrn_val_i = 1'b1; l15_rtrn_payload_i = r_vals[0];
    for (int c = 0; c < 12; c++) begin
      tick();
      if (l15_seen_ack) begin
        l15_seen_ack = 0; idx++;
        if (idx < 3) l15_rtrn_payload_i = r_vals[idx];
        else l15_rtrn_val_i = 1'b0;
      end else if (l15_req_ack_o) begin
        l15_seen_ack = 1; acks++;
      end
    end
    chk("rtrn_acks_while_full", acks, 2);
    chk("rtrn_r2_held_val", l15_rtrn_val_i, 1);
    chk("rtrn_full_no_ack", l15_req_ack_o, 0);
    chk("rtrn_head_r0", core_rtrn_payload_o, r_vals[0]);

    // pop R0 while full; R2 enters in the same edge
    core_rtrn_ack_i = 1'b1;
    tick();
    core_rtrn_ack_i = 1'b0;
    chk("rtrn_push_on_pop_ack", l15_req_ack_o, 1);
    chk("rtrn_gap_after_pop", core_rtrn_val_o, 0);
    l15_seen_ack = 1; acks++;
    tick();
    l15_seen_ack = 0; l15_rtrn_val_i = 1'b0;
    chk("rtrn_head_r1", core_rtrn_payload_o, r_vals[1]);

    // core ack held high with two entries: alternate-cycle pops, exactly two
    core_rtrn_ack_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (core_rtrn_val_o) popped.push_back(core_rtrn_payload_o);
      tick();
    end
    core_rtrn_ack_i = 1'b0;
    chk("rtrn_pop_count", popped.size(), 2);
    if (popped.size() == 2) begin
      chk("rtrn_order_0", popped[0], r_vals[1]);
      chk("rtrn_order_1", popped[1], r_vals[2]);
    end
    chk("rtrn_total_acks", acks, 3);

    // ---- asynchronous reset in PEND with one FIFO entry
    core_req_val_i = 1'b1; core_req_payload_i = rand_vec()[REQ_W-1:0];
    l15_rtrn_val_i = 1'b1; l15_rtrn_payload_i = rand_vec();
    tick();
    core_req_val_i = 1'b0;
    tick();
    l15_rtrn_val_i = 1'b0;
    tick();
    chk("prerst_l15_req_val", l15_req_val_o, 1);
    chk("prerst_core_rtrn_val", core_rtrn_val_o, 1);
    #2 rst_ni = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    check_all();
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("postrst_no_replay", l15_req_val_o, 0);
      chk("postrst_no_rtrn", core_rtrn_val_o, 0);
    end

    // ---- randomized traffic
    l15_seen_ack = 0; core_seen_ack = 0; mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 64) == 0) mode = $urandom_range(0, 2);
      // core request side: hold until header ack, change only after it
      if (core_seen_ack) begin
        core_seen_ack = 0;
        core_req_val_i = ($urandom_range(0, 1) == 0);
        core_req_payload_i = rand_vec()[REQ_W-1:0];
      end else if (core_req_header_ack_o) begin
        core_seen_ack = 1;
      end else if (!core_req_val_i && ($urandom_range(0, 2) == 0)) begin
        core_req_val_i = 1'b1;
        core_req_payload_i = rand_vec()[REQ_W-1:0];
      end
      // L1.5 header ack, including spurious pulses outside a pending request
      l15_header_ack_i = ($urandom_range(0, 3) == 0);
      // L1.5 return side: hold through the ack cycle, change afterwards
      if (l15_seen_ack) begin
        l15_seen_ack = 0;
        l15_rtrn_val_i = ($urandom_range(0, 1) == 0);
        l15_rtrn_payload_i = rand_vec();
      end else if (l15_req_ack_o) begin
        l15_seen_ack = 1;
      end else if (!l15_rtrn_val_i && ($urandom_range(0, 1) == 0)) begin
        l15_rtrn_val_i = 1'b1;
        l15_rtrn_payload_i = rand_vec();
      end
      case (mode)
        0:       core_rtrn_ack_i = ($urandom_range(0, 1) == 0);
        1:       core_rtrn_ack_i = 1'b1;
        default: core_rtrn_ack_i = ($urandom_range(0, 9) == 0);
      endcase
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
